rx_word_packer: RTL and testbench

RX_WORD_PACKER -- requirements
Module: rx_word_packer

---
 rtl/rx_word_packer.sv | 145 ++++++++++++++
 tb/tb_rx_word_packer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_word_packer.sv
// rx_word_packer: packs bytes popped from a first-word-fall-through FIFO into
// little-endian words of BYTES_PER_WORD bytes. Partial words leave on flush_i.
// Optional build macro RX_PACK_TIMEOUT_EN adds an idle timer that raises an
// automatic flush after TIMEOUT_CYCLES idle cycles with a partial word held.
//
// Output handshake: a word transfers on a rising edge where word_valid_o=1 and
// word_ready_i=1. Once raised, word_valid_o, word_data_o and word_keep_o hold
// steady until that transfer; word_valid_o never depends on word_ready_i.
module rx_word_packer #(
    parameter int DATA_WIDTH     = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                 rx_clk,
    input  logic                                 rx_rst,
    input  logic                                 fifo_empty_i,
    input  logic [DATA_WIDTH-1:0]                fifo_data_i,
    output logic                                 fifo_rd_en_o,
    input  logic                                 flush_i,
    output logic                                 word_valid_o,
    input  logic                                 word_ready_i,
    output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] word_data_o,
    output logic [BYTES_PER_WORD-1:0]            word_keep_o
);

    localparam int WORD_W = DATA_WIDTH * BYTES_PER_WORD;
    localparam int CNT_W  = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BYTES_PER_WORD - 1);

    // Packer states; the state is carried by the byte count itself.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    logic [CNT_W-1:0]          cnt;
    logic [WORD_W-1:0]         acc;
    logic [WORD_W-1:0]         merged;
    logic [BYTES_PER_WORD-1:0] partial_keep;
    logic [0:0]                pack_state;
    logic                      flush_pend;
    logic                      slot_free;
    logic                      flush_req;
    logic                      flush_fire;
    logic                      accept;
    logic                      last_accept;
    logic                      timeout_req;

    assign pack_state   = (cnt == '0) ? ST_EMPTY : ST_ACCUM;
    assign slot_free    = ~word_valid_o | word_ready_i;
    assign flush_req    = flush_i | flush_pend | timeout_req;
    assign flush_fire   = flush_req & (pack_state == ST_ACCUM) & slot_free;
    // The last byte of a word may only be popped when the output slot can take it.
    assign fifo_rd_en_o = ~rx_rst & ~fifo_empty_i & ~flush_fire &
                          ((cnt != LAST_IDX) | slot_free);
    assign accept       = fifo_rd_en_o;
    assign last_accept  = accept & (cnt == LAST_IDX);

    // Accumulated bytes with the current FIFO head dropped into slot cnt.
    always_comb begin
        merged = acc;
        merged[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] = fifo_data_i;
    end

    // Keep mask for a partial word: the low cnt bytes are valid.
    always_comb begin
        partial_keep = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            partial_keep[i] = (i < int'(cnt));
        end
    end

    // Byte count: advances per accepted byte, returns to zero when a word leaves.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            cnt <= '0;
        end else if (last_accept || flush_fire) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Accumulator: cleared whenever a word leaves so unused bytes read as zero.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            acc <= '0;
        end else if (last_accept || flush_fire) begin
            acc <= '0;
        end else if (accept) begin
            acc <= merged;
        end
    end

    // Pending flush: remembers a flush that arrived while the output slot was busy.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            flush_pend <= 1'b0;
        end else if (flush_fire) begin
            flush_pend <= 1'b0;
        end else if (flush_req && (pack_state == ST_ACCUM) && !slot_free) begin
            flush_pend <= 1'b1;
        end else if (pack_state == ST_EMPTY) begin
            flush_pend <= 1'b0;
        end
    end

    // Output register: loads a full or flushed word, drops valid on transfer.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            word_valid_o <= 1'b0;
            word_data_o  <= '0;
            word_keep_o  <= '0;
        end else if (last_accept) begin
            word_valid_o <= 1'b1;
            word_data_o  <= merged;
            word_keep_o  <= '1;
        end else if (flush_fire) begin
            word_valid_o <= 1'b1;
            word_data_o  <= acc;
            word_keep_o  <= partial_keep;
        end else if (word_ready_i) begin
            word_valid_o <= 1'b0;
        end
    end

`ifdef RX_PACK_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] idle_cnt;

    // Idle timer: counts cycles with a partial word held and nothing popped.
    always_ff @(posedge rx_clk) begin
        if (rx_rst || accept || (pack_state == ST_EMPTY)) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TMO_LIMIT) begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end

    assign timeout_req = (idle_cnt == TMO_LIMIT);
`else
    // No idle timer in this build; TIMEOUT_CYCLES only keeps the parameter list stable.
    assign timeout_req = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_rx_word_packer.sv
// tb_rx_word_packer: directed vector table, hand-written corner sequences and a
// randomized run for rx_word_packer (DATA_WIDTH=8, BYTES_PER_WORD=4).
module tb_rx_word_packer;

  localparam int DW  = 8;
  localparam int BPW = 4;
  localparam int WW  = DW * BPW;

  logic           rx_clk = 1'b0;
  logic           rx_rst;
  logic           fifo_empty_i;
  logic [DW-1:0]  fifo_data_i;
  logic           fifo_rd_en_o;
  logic           flush_i;
  logic           word_valid_o;
  logic           word_ready_i;
  logic [WW-1:0]  word_data_o;
  logic [BPW-1:0] word_keep_o;

  rx_word_packer #(
    .DATA_WIDTH     (DW),
    .BYTES_PER_WORD (BPW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .rx_clk       (rx_clk),
    .rx_rst       (rx_rst),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .flush_i      (flush_i),
    .word_valid_o (word_valid_o),
    .word_ready_i (word_ready_i),
    .word_data_o  (word_data_o),
    .word_keep_o  (word_keep_o)
  );

  // clock / reset block
  always #5 rx_clk = ~rx_clk;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  int words = 0;

  logic [DW-1:0]  exp_q[$];   // bytes popped and not yet seen in an output word
  logic [DW-1:0]  src_q[$];   // FIFO contents model
  logic           hold_empty;
  logic           d_empty;

  logic           s_rd, s_valid;
  logic [WW-1:0]  s_data;
  logic [BPW-1:0] s_keep;
  logic           p_valid = 1'b0;
  logic           p_ready = 1'b0;
  logic           p_rst   = 1'b1;
  logic [WW-1:0]  p_data  = '0;
  logic [BPW-1:0] p_keep  = '0;
  logic [WW-1:0]  last_word = '0;
  logic [BPW-1:0] last_keep = '0;

  typedef struct {
    logic          empty;
    logic [DW-1:0] data;
    logic          flush;
    logic          ready;
    logic          exp_rd;
    logic          exp_valid;
    logic          chk_word;
    logic [WW-1:0] exp_data;
    logic [BPW-1:0] exp_keep;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: an accepted word must be the next n popped bytes, low-aligned
  task automatic score_word(input logic [WW-1:0] data, input logic [BPW-1:0] keep);
    int n;
    logic [WW-1:0]  e;
    logic [BPW-1:0] m;
    n = $countones(keep);
    e = '0;
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    check("keep_nonzero", (n > 0), 1'b1);
    check("keep_shape", keep, m);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", exp_q.size(), 1);
        break;
      end
      e[i*DW +: DW] = exp_q.pop_front();
    end
    check("word_data", data, e);
    last_word = data;
    last_keep = keep;
    words++;
  endtask

  // driver: one clock cycle with the given inputs; samples on the falling edge
  task automatic cycle(input logic empty, input logic [DW-1:0] data,
                       input logic flush, input logic ready);
    fifo_empty_i = empty;
    fifo_data_i  = data;
    flush_i      = flush;
    word_ready_i = ready;
    d_empty      = empty;
    @(negedge rx_clk);
    s_rd    = fifo_rd_en_o;
    s_valid = word_valid_o;
    s_data  = word_data_o;
    s_keep  = word_keep_o;
    check("no_pop_when_empty", s_rd & empty, 1'b0);
    if (p_valid && !p_ready && !p_rst) begin
      check("hold_valid", s_valid, 1'b1);
      check("hold_data", s_data, p_data);
      check("hold_keep", s_keep, p_keep);
    end
    @(posedge rx_clk);
    if (s_valid && ready && !rx_rst) score_word(s_data, s_keep);
    if (s_rd && !rx_rst) begin
      exp_q.push_back(data);
      pops++;
    end
    p_valid = s_valid;
    p_ready = ready;
    p_data  = s_data;
    p_keep  = s_keep;
    p_rst   = rx_rst;
    #1;
  endtask

  // driver: FIFO model feeds the packer from src_q
  task automatic fifo_cycle(input logic flush, input logic ready);
    logic e;
    logic [DW-1:0] d;
    e = hold_empty || (src_q.size() == 0);
    d = e ? '0 : src_q[0];
    cycle(e, d, flush, ready);
    if (s_rd && !e) void'(src_q.pop_front());
  endtask

  task automatic do_reset();
    rx_rst = 1'b1;
    cycle(1'b0, 8'h5A, 1'b0, 1'b0);
    check("rd_en_in_reset", s_rd, 1'b0);
    rx_rst = 1'b0;
    exp_q.delete();
    src_q.delete();
    hold_empty = 1'b0;
  endtask

  initial begin
    int first;
    int vcount;
    int wbefore;
    logic [BPW-1:0] kfirst;
    logic rdy, fl;

    rx_rst       = 1'b1;
    fifo_empty_i = 1'b1;
    fifo_data_i  = '0;
    flush_i      = 1'b0;
    word_ready_i = 1'b0;
    hold_empty   = 1'b0;
    d_empty      = 1'b1;

    // ---- vector table: full word, flushed partial, flushes at cnt=0 ----
    tbl[0]  = '{1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0,        4'h0};
    tbl[1]  = '{1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0};
    tbl[2]  = '{1'b0, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0};
    tbl[3]  = '{1'b0, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0};
    tbl[4]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h44332211, 4'hF};
    tbl[5]  = '{1'b0, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0};
    tbl[6]  = '{1'b0, 8'hBB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0};
    tbl[7]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0};
    tbl[8]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000BBAA, 4'h3};
    tbl[9]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0};
    tbl[10] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0};
    tbl[11] = '{1'b0, 8'hCC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        4'h0};
    tbl[12] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0};
    tbl[13] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        4'h0};
    tbl[14] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h000000CC, 4'h1};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].empty, tbl[i].data, tbl[i].flush, tbl[i].ready);
      check($sformatf("tbl%0d_rd_en", i), s_rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_valid", i), s_valid, tbl[i].exp_valid);
      if (tbl[i].chk_word) begin
        check($sformatf("tbl%0d_data", i), s_data, tbl[i].exp_data);
        check($sformatf("tbl%0d_keep", i), s_keep, tbl[i].exp_keep);
      end
    end

    // ---- stall: 8 bytes with ready low; the last byte of word 2 waits ----
    do_reset();
    for (int i = 1; i <= 8; i++) src_q.push_back(8'(i));
    pops = 0;
    for (int i = 0; i < 12; i++) fifo_cycle(1'b0, 1'b0);
    check("stall_pops", pops, 7);
    check("stall_rd_en_blocked", s_rd, 1'b0);
    check("stall_word1_valid", s_valid, 1'b1);
    check("stall_word1_data", s_data, 32'h04030201);
    fifo_cycle(1'b0, 1'b1);
    check("stall_last_pop_on_ready", s_rd, 1'b1);
    fifo_cycle(1'b0, 1'b1);
    check("stall_word2_valid", s_valid, 1'b1);
    check("stall_word2_data", s_data, 32'h08070605);
    fifo_cycle(1'b0, 1'b1);
    check("stall_drained", s_valid, 1'b0);

    // ---- flush while the output is stalled with cnt=1 ----
    do_reset();
    for (int i = 1; i <= 5; i++) src_q.push_back(8'(i * 16));
    for (int i = 0; i < 8; i++) fifo_cycle(1'b0, 1'b0);
    fifo_cycle(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) fifo_cycle(1'b0, 1'b0);
    check("pend_word1_held", s_data, 32'h40302010);
    src_q.push_back(8'h99);
    fifo_cycle(1'b0, 1'b1);
    check("pend_no_pop_on_fire", s_rd, 1'b0);
    fifo_cycle(1'b0, 1'b0);
    check("pend_partial_valid", s_valid, 1'b1);
    check("pend_partial_keep", s_keep, 4'h1);
    check("pend_partial_data", s_data, 32'h00000050);
    fifo_cycle(1'b0, 1'b1);

    // ---- reset with cnt=2 and a stalled word ----
    do_reset();
    for (int i = 1; i <= 6; i++) src_q.push_back(8'(i));
    for (int i = 0; i < 8; i++) fifo_cycle(1'b0, 1'b0);
    check("rst_setup_valid", s_valid, 1'b1);
    do_reset();
    src_q.push_back(8'hA1);
    src_q.push_back(8'hA2);
    src_q.push_back(8'hA3);
    src_q.push_back(8'hA4);
    wbefore = words;
    fifo_cycle(1'b0, 1'b1);
    check("rst_valid_cleared", s_valid, 1'b0);
    for (int i = 0; i < 5; i++) fifo_cycle(1'b0, 1'b1);
    check("rst_fresh_word_count", words, wbefore + 1);
    check("rst_fresh_keep", last_keep, 4'hF);
    check("rst_fresh_data", last_word, 32'hA4A3A2A1);

    // ---- partial word with the FIFO running dry ----
    do_reset();
    src_q.push_back(8'h0A);
    src_q.push_back(8'h0B);
    src_q.push_back(8'h0C);
    for (int i = 0; i < 3; i++) fifo_cycle(1'b0, 1'b1);
`ifdef RX_PACK_TIMEOUT_EN
    first  = -1;
    kfirst = '0;
    for (int k = 0; k < 30; k++) begin
      fifo_cycle(1'b0, 1'b1);
      if (s_valid && first < 0) begin
        first  = k;
        kfirst = s_keep;
      end
    end
    check("tmo_latency", first, 17);
    check("tmo_keep", kfirst, 4'h7);
`else
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      fifo_cycle(1'b0, 1'b1);
      if (s_valid) vcount++;
    end
    check("no_tmo_output", vcount, 0);
    fifo_cycle(1'b1, 1'b1);
    fifo_cycle(1'b0, 1'b1);
    check("manual_flush_valid", s_valid, 1'b1);
    check("manual_flush_keep", s_keep, 4'h7);
    check("manual_flush_data", s_data, 32'h000C0B0A);
`endif

    // ---- randomized run against the byte-stream scoreboard ----
    do_reset();
    for (int i = 0; i < 700; i++) begin
      while (src_q.size() < 4) src_q.push_back(8'($urandom_range(0, 255)));
      hold_empty = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      fl  = (i >= 350) && ($urandom_range(0, 19) == 0);
      fifo_cycle(fl, rdy);
`ifndef RX_PACK_TIMEOUT_EN
      if (i < 350 && rdy && !d_empty) check("pop_when_slot_free", s_rd, 1'b1);
`endif
    end
    hold_empty = 1'b1;
    for (int i = 0; i < 3; i++) fifo_cycle(1'b0, 1'b1);
    fifo_cycle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) fifo_cycle(1'b0, 1'b1);
    check("rand_all_bytes_out", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
